// File: rtl/if_inst_queue_pkg.sv
// Shared widths and helpers for the fetch-to-decode instruction queue.
package if_inst_queue_pkg;

  // Stage bus width carried from IF to ID: PC, instruction, exception info, BTB/predict fields.
  localparam int IF_TO_ID_WD = 100;

  // Queue geometry.
  localparam int IFQ_DEPTH   = 4;
  localparam int IFQ_MAX_OUT = 4;

  // What happens to a cache response arriving this cycle.
  typedef enum logic [1:0] {
    RESP_NONE     = 2'd0,
    RESP_DROP_CXL = 2'd1,
    RESP_PUSH     = 2'd2,
    RESP_ERR      = 2'd3
  } resp_kind_e;

  // Cancelled responses are oldest so they drain first; live ones are stored; anything else is stray.
  function automatic resp_kind_e classify_resp(input logic valid,
                                               input logic cxl_nz,
                                               input logic out_nz);
    resp_kind_e kind;
    kind = RESP_NONE;
    if (valid) begin
      if (cxl_nz)      kind = RESP_DROP_CXL;
      else if (out_nz) kind = RESP_PUSH;
      else             kind = RESP_ERR;
    end
    return kind;
  endfunction

endpackage

// File: rtl/if_inst_queue_storage.sv
// Register array holding queued fetch payloads: one write port, one combinational read port.
module ifq_storage
  import if_inst_queue_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int DATA_W = IF_TO_ID_WD,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Entry write; the array is cleared on reset so no stale payload can ever be observed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_inst_queue.sv
// Fetch-side decoupling queue: buffers I-cache responses for decode and discards flushed-path responses.
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int DEPTH   = IFQ_DEPTH,
  parameter int DATA_W  = IF_TO_ID_WD,
  parameter int MAX_OUT = IFQ_MAX_OUT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  output logic              inst_req_ready,
  input  logic              inst_req_fire,
  input  logic              inst_resp_valid,
  input  logic [DATA_W-1:0] inst_resp_data,
  input  logic              ID_allowin,
  output logic              IF_ID_valid,
  output logic [DATA_W-1:0] IF_to_ID_bus,
  output logic              resp_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QC_W  = $clog2(DEPTH + 1);
  localparam int OC_W  = $clog2(MAX_OUT + 1);
  localparam int SUM_W = ((QC_W > OC_W) ? QC_W : OC_W) + 2;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QC_W-1:0]   q_cnt_q, q_cnt_d;
  logic [OC_W-1:0]   out_cnt_q, out_cnt_d, cxl_cnt_q, cxl_cnt_d;
  logic              resp_err_q, resp_err_d;
  logic              push, pop, q_nonempty;
  logic [SUM_W-1:0]  pend_sum;
  logic [DATA_W-1:0] rdata;
  resp_kind_e        resp_kind;

  assign q_nonempty = (q_cnt_q != '0);
  assign resp_kind  = classify_resp(inst_resp_valid, cxl_cnt_q != '0, out_cnt_q != '0);

  // Every live request owns a queue slot in advance, so a returning response always has room.
  assign inst_req_ready = ((SUM_W'(q_cnt_q) + SUM_W'(out_cnt_q)) < SUM_W'(DEPTH)) &&
                          ((SUM_W'(out_cnt_q) + SUM_W'(cxl_cnt_q)) < SUM_W'(MAX_OUT)) &&
                          !flush;

  assign IF_ID_valid  = q_nonempty && !flush;
  assign IF_to_ID_bus = q_nonempty ? rdata : '0;
  assign pop          = IF_ID_valid && ID_allowin;

  // Next-state for pointers and counters; a flush empties the queue and turns live requests into cancelled ones.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_cnt_d    = q_cnt_q;
    out_cnt_d  = out_cnt_q;
    cxl_cnt_d  = cxl_cnt_q;
    resp_err_d = resp_err_q;
    pend_sum   = '0;
    push       = 1'b0;

    if (resp_kind == RESP_ERR) resp_err_d = 1'b1;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      q_cnt_d   = '0;
      out_cnt_d = '0;
      pend_sum  = SUM_W'(cxl_cnt_q) + SUM_W'(out_cnt_q) + SUM_W'(inst_req_fire);
      if (inst_resp_valid && (pend_sum != '0)) pend_sum = pend_sum - SUM_W'(1);
      cxl_cnt_d = OC_W'(pend_sum);
    end else begin
      push      = (resp_kind == RESP_PUSH);
      if (resp_kind == RESP_DROP_CXL) cxl_cnt_d = cxl_cnt_q - OC_W'(1);
      out_cnt_d = out_cnt_q + OC_W'(inst_req_fire) - OC_W'(push);
      q_cnt_d   = q_cnt_q + QC_W'(push) - QC_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Queue bookkeeping registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      q_cnt_q    <= '0;
      out_cnt_q  <= '0;
      cxl_cnt_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      q_cnt_q    <= q_cnt_d;
      out_cnt_q  <= out_cnt_d;
      cxl_cnt_q  <= cxl_cnt_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;

  ifq_storage #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_storage (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (inst_resp_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed bench for the fetch-to-decode instruction queue.
module tb_if_inst_queue;
  import if_inst_queue_pkg::*;

  localparam int W = IF_TO_ID_WD;

  logic         clk;
  logic         resetn;
  logic         flush;
  logic         inst_req_ready;
  logic         inst_req_fire;
  logic         inst_resp_valid;
  logic [W-1:0] inst_resp_data;
  logic         ID_allowin;
  logic         IF_ID_valid;
  logic [W-1:0] IF_to_ID_bus;
  logic         resp_err;

  int checks = 0;
  int errors = 0;

  if_inst_queue dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .inst_req_ready  (inst_req_ready),
    .inst_req_fire   (inst_req_fire),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_data  (inst_resp_data),
    .ID_allowin      (ID_allowin),
    .IF_ID_valid     (IF_ID_valid),
    .IF_to_ID_bus    (IF_to_ID_bus),
    .resp_err        (resp_err)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload built from a PC: PC in the low word, inverted PC standing in for the instruction word.
  function automatic logic [W-1:0] mk(input logic [31:0] pc);
    logic [W-1:0] r;
    r        = '0;
    r[31:0]  = pc;
    r[63:32] = ~pc;
    r[W-1:W-4] = pc[5:2];
    return r;
  endfunction

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; inst_req_fire = 1'b0; inst_resp_valid = 1'b0;
    inst_resp_data = '0; ID_allowin = 1'b0;
    tick(); tick();
    settle();
    checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", IF_ID_valid); end
    checks++; if (IF_to_ID_bus !== '0) begin errors++; $display("[TB] FAIL reset_bus got %h want 0", IF_to_ID_bus); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", resp_err); end
    checks++; if (inst_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", inst_req_ready); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [31:0] pc;
    ID_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++; if (inst_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready_%0d got %b want 1", i, inst_req_ready); end
      inst_req_fire = 1'b1;
      tick();
    end
    inst_req_fire = 1'b0;
    settle();
    checks++; if (inst_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready_after4 got %b want 0", inst_req_ready); end
    for (int i = 0; i < 4; i++) begin
      pc = 32'hBFC0_0000 + 32'(4 * i);
      inst_resp_valid = 1'b1; inst_resp_data = mk(pc);
      tick();
    end
    inst_resp_valid = 1'b0;
    settle();
    checks++; if (inst_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %b want 0", inst_req_ready); end
    ID_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'hBFC0_0000 + 32'(4 * i);
      settle();
      checks++; if (IF_ID_valid !== 1'b1 || IF_to_ID_bus !== mk(pc))
        begin errors++; $display("[TB] FAIL drain_%0d got v=%b bus=%h want v=1 bus=%h", i, IF_ID_valid, IF_to_ID_bus, mk(pc)); end
      tick();
    end
    settle();
    checks++; if (IF_ID_valid !== 1'b0 || IF_to_ID_bus !== '0)
      begin errors++; $display("[TB] FAIL drain_empty got v=%b bus=%h want v=0 bus=0", IF_ID_valid, IF_to_ID_bus); end
    checks++; if (inst_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_ready got %b want 1", inst_req_ready); end
    ID_allowin = 1'b0;
  endtask

  task automatic test_flush_inflight();
    ID_allowin = 1'b0;
    inst_req_fire = 1'b1; tick(); tick();
    inst_req_fire = 1'b0;
    flush = 1'b1;
    settle();
    checks++; if (inst_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready got %b want 0", inst_req_ready); end
    tick();
    flush = 1'b0;
    inst_resp_valid = 1'b1; inst_resp_data = mk(32'h100); tick();
    inst_resp_data = mk(32'h104); tick();
    inst_resp_valid = 1'b0;
    settle();
    checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop got v=%b want 0", IF_ID_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL flush_err got %b want 0", resp_err); end
    inst_req_fire = 1'b1; tick();
    inst_req_fire = 1'b0;
    inst_resp_valid = 1'b1; inst_resp_data = mk(32'h380); tick();
    inst_resp_valid = 1'b0;
    settle();
    checks++; if (IF_ID_valid !== 1'b1 || IF_to_ID_bus !== mk(32'h380))
      begin errors++; $display("[TB] FAIL flush_refetch got v=%b bus=%h want v=1 bus=%h", IF_ID_valid, IF_to_ID_bus, mk(32'h380)); end
    ID_allowin = 1'b1; tick();
    ID_allowin = 1'b0;
    settle();
    checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_popped got v=%b want 0", IF_ID_valid); end
  endtask

  task automatic test_flush_coincident();
    ID_allowin = 1'b0;
    inst_req_fire = 1'b1; tick(); tick();
    flush = 1'b1; inst_req_fire = 1'b1;
    inst_resp_valid = 1'b1; inst_resp_data = mk(32'h200);
    tick();
    flush = 1'b0; inst_req_fire = 1'b0;
    inst_resp_data = mk(32'h204); tick();
    settle();
    checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL coinc_drop1 got v=%b want 0", IF_ID_valid); end
    inst_resp_data = mk(32'h208); tick();
    inst_resp_valid = 1'b0;
    settle();
    checks++; if (IF_ID_valid !== 1'b0 || resp_err !== 1'b0)
      begin errors++; $display("[TB] FAIL coinc_drop2 got v=%b err=%b want v=0 err=0", IF_ID_valid, resp_err); end
    inst_req_fire = 1'b1; tick();
    inst_req_fire = 1'b0;
    inst_resp_valid = 1'b1; inst_resp_data = mk(32'h20C); tick();
    inst_resp_valid = 1'b0;
    settle();
    checks++; if (IF_ID_valid !== 1'b1 || IF_to_ID_bus !== mk(32'h20C) || resp_err !== 1'b0)
      begin errors++; $display("[TB] FAIL coinc_live got v=%b bus=%h err=%b want v=1 bus=%h err=0", IF_ID_valid, IF_to_ID_bus, resp_err, mk(32'h20C)); end
    ID_allowin = 1'b1; tick();
    ID_allowin = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    base = 32'h0000_4000;
    ID_allowin = 1'b1;
    inst_req_fire = 1'b1; tick();
    inst_resp_valid = 1'b1; inst_resp_data = mk(base); tick();
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++; if (IF_ID_valid !== 1'b1 || IF_to_ID_bus !== mk(base + 32'(4 * i)))
        begin errors++; $display("[TB] FAIL b2b_%0d got v=%b bus=%h want v=1 bus=%h", i, IF_ID_valid, IF_to_ID_bus, mk(base + 32'(4 * i))); end
      inst_resp_data = mk(base + 32'(4 * (i + 1)));
      inst_req_fire  = (i < 7);
      tick();
    end
    inst_resp_valid = 1'b0; inst_req_fire = 1'b0;
    settle();
    checks++; if (IF_ID_valid !== 1'b1 || IF_to_ID_bus !== mk(base + 32'd32))
      begin errors++; $display("[TB] FAIL b2b_last got v=%b bus=%h want v=1 bus=%h", IF_ID_valid, IF_to_ID_bus, mk(base + 32'd32)); end
    tick();
    settle();
    checks++; if (IF_ID_valid !== 1'b0 || inst_req_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL b2b_empty got v=%b rdy=%b want v=0 rdy=1", IF_ID_valid, inst_req_ready); end
    ID_allowin = 1'b0;
  endtask

  task automatic test_unexpected_resp();
    ID_allowin = 1'b0;
    settle();
    checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL stray_pre got %b want 0", resp_err); end
    inst_resp_valid = 1'b1; inst_resp_data = mk(32'hDEAD_0000); tick();
    inst_resp_valid = 1'b0;
    settle();
    checks++; if (resp_err !== 1'b1 || IF_ID_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL stray_set got err=%b v=%b want err=1 v=0", resp_err, IF_ID_valid); end
    tick(); tick(); tick();
    settle();
    checks++; if (resp_err !== 1'b1 || IF_ID_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL stray_sticky got err=%b v=%b want err=1 v=0", resp_err, IF_ID_valid); end
  endtask

  task automatic test_async_reset();
    ID_allowin = 1'b0;
    inst_req_fire = 1'b1; tick(); tick(); tick();
    inst_req_fire = 1'b0;
    inst_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_resp_data = mk(32'h600 + 32'(4 * i));
      tick();
    end
    inst_resp_valid = 1'b0;
    settle();
    checks++; if (IF_ID_valid !== 1'b1 || IF_to_ID_bus !== mk(32'h600))
      begin errors++; $display("[TB] FAIL areset_pre got v=%b bus=%h want v=1 bus=%h", IF_ID_valid, IF_to_ID_bus, mk(32'h600)); end
    resetn = 1'b0;
    #1;
    checks++; if (IF_ID_valid !== 1'b0 || IF_to_ID_bus !== '0 || resp_err !== 1'b0)
      begin errors++; $display("[TB] FAIL areset_now got v=%b bus=%h err=%b want v=0 bus=0 err=0", IF_ID_valid, IF_to_ID_bus, resp_err); end
    tick();
    resetn = 1'b1;
    tick();
    settle();
    checks++; if (inst_req_ready !== 1'b1 || IF_ID_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL areset_post got rdy=%b v=%b want rdy=1 v=0", inst_req_ready, IF_ID_valid); end
    inst_req_fire = 1'b1; tick();
    inst_req_fire = 1'b0;
    inst_resp_valid = 1'b1; inst_resp_data = mk(32'h500); tick();
    inst_resp_valid = 1'b0;
    settle();
    checks++; if (IF_ID_valid !== 1'b1 || IF_to_ID_bus !== mk(32'h500))
      begin errors++; $display("[TB] FAIL areset_fresh got v=%b bus=%h want v=1 bus=%h", IF_ID_valid, IF_to_ID_bus, mk(32'h500)); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_fill_drain();
    test_flush_inflight();
    test_flush_coincident();
    test_back_to_back();
    test_unexpected_resp();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
